// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: oversamples SCLK/CS_N/MOSI in the clk domain,
// assembles one FRAME_BITS command frame per chip-select window and returns RESP_BITS on MISO.
module spi_frame_rx #(
  parameter int unsigned FRAME_BITS  = 100,
  parameter int unsigned RESP_BITS   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic [RESP_BITS-1:0]  resp_data,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   started, armed;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [FRAME_BITS-1:0]  sr, sr_n, data_n;
  logic [RESP_BITS-1:0]   resp_sr, resp_n;
  logic                   miso_n, valid_n, err_n, overrun, overrun_n;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  // A window only opens after CS_N has been seen high at the pin since reset,
  // so a CS_N already low when reset releases cannot start a frame.
  assign cs_fall   = armed & ~cs_s & cs_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
      started   <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
      started   <= 1'b1;
      if (started && cs_sync[0]) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sr          <= '0;
      resp_sr     <= '0;
      spi_miso    <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      sr          <= sr_n;
      resp_sr     <= resp_n;
      spi_miso    <= miso_n;
      frame_data  <= data_n;
      frame_valid <= valid_n;
      frame_err   <= err_n;
      overrun     <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sr_n      = sr;
    resp_n    = resp_sr;
    miso_n    = spi_miso;
    data_n    = frame_data;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    overrun_n = overrun;
    unique case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (cs_fall) begin
          state_n   = SHIFT;
          cnt_n     = '0;
          sr_n      = '0;
          resp_n    = resp_data;
          miso_n    = resp_data[RESP_BITS-1];
          overrun_n = 1'b0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_n = IDLE;
          err_n   = 1'b1;
          miso_n  = 1'b0;
        end else if (sclk_rise) begin
          sr_n    = sr << 1;
          sr_n[0] = mosi_s;
          if (cnt != CNT_W'(FRAME_BITS)) cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(FRAME_BITS - 1)) begin
            data_n  = sr_n;
            valid_n = 1'b1;
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (cs_rise) begin
          state_n = IDLE;
          err_n   = overrun;
          miso_n  = 1'b0;
        end else if (sclk_rise) begin
          overrun_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Response keeps shifting (zero-filled) for the whole window, so MISO reads 0 once drained.
    if (state != IDLE && !cs_rise && sclk_fall) begin
      resp_n = resp_sr << 1;
      miso_n = resp_n[RESP_BITS-1];
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a Pi-side SPI master model drives windows at SCLK = clk/10.
module tb_spi_frame_rx;

  localparam int FB = 100;
  localparam int RB = 32;
  localparam int SS = 2;

  localparam logic [FB-1:0] NOM  = {1'b1, 1'b1, 2'b10, 32'hDEADBEEF, 32'h8000_0004, 32'h0000_1234};
  localparam logic [FB-1:0] OVF  = {4'h9, 96'h0123_4567_89AB_CDEF_FEDC_BA98};
  localparam logic [FB-1:0] PATA = {25{4'hA}};
  localparam logic [FB-1:0] PATB = {25{4'h5}};
  localparam logic [FB-1:0] RSTF = {4'h6, 96'hC001_D00D_1357_9BDF_2468_ACE0};
  localparam logic [RB-1:0] RESP = 32'hA5A5_0F0F;

  logic          clk = 1'b0;
  logic          reset_n, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [RB-1:0] resp_data;
  logic [FB-1:0] frame_data;
  logic          frame_valid, frame_err, busy;

  int vectors = 0, miscompares = 0;
  int cyc = 0, valid_cnt = 0, err_cnt = 0, both_cnt = 0, valid_cyc = 0, rise_cyc = 0;
  logic [FB-1:0] last_frame = '0;

  spi_frame_rx #(.FRAME_BITS(FB), .RESP_BITS(RB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .resp_data(resp_data),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_valid) begin
      valid_cnt  = valid_cnt + 1;
      valid_cyc  = cyc;
      last_frame = frame_data;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (frame_valid && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    #50;
    spi_sclk = 1'b1;
    m = spi_miso;
    rise_cyc = cyc;
    #50;
    spi_sclk = 1'b0;
  endtask

  task automatic spi_window(input logic [127:0] bits, input int n, output logic [127:0] cap);
    logic m;
    cap = '0;
    spi_cs_n = 1'b0;
    #100;
    for (int i = 0; i < n; i++) begin
      spi_bit(bits[127-i], m);
      cap[127-i] = m;
    end
    #50;
    spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    vectors++; if (frame_data !== '0) begin miscompares++; $display("FAIL reset_frame_data: got %h expected 0", frame_data); end
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_nominal();
    logic [127:0] cap;
    int v0, e0, lat;
    v0 = valid_cnt; e0 = err_cnt;
    resp_data = RESP;
    spi_window({NOM, 28'h0}, 100, cap);
    lat = valid_cyc - rise_cyc;
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL nominal_valid_pulses: got %0d expected 1", valid_cnt - v0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL nominal_err_pulses: got %0d expected 0", err_cnt - e0); end
    vectors++; if (frame_data !== NOM) begin miscompares++; $display("FAIL nominal_frame_data: got %h expected %h", frame_data, NOM); end
    vectors++; if (last_frame !== NOM) begin miscompares++; $display("FAIL nominal_data_at_valid: got %h expected %h", last_frame, NOM); end
    vectors++; if (lat < SS + 1 || lat > SS + 3) begin miscompares++; $display("FAIL nominal_latency: got %0d clk expected %0d..%0d", lat, SS + 1, SS + 3); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nominal_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_miso();
    logic [127:0] cap;
    logic [99:0]  got;
    logic [99:0]  exp;
    resp_data = RESP;
    spi_window({PATB, 28'h0}, 100, cap);
    resp_data = 32'h0;
    got = cap[127:28];
    exp = {RESP, 68'h0};
    vectors++; if (got !== exp) begin miscompares++; $display("FAIL miso_readback: got %h expected %h", got, exp); end
    vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL miso_idle: got %b expected 0", spi_miso); end
  endtask

  task automatic test_short();
    logic [127:0] cap;
    int v0, e0;
    spi_window({NOM, 28'h0}, 100, cap);
    v0 = valid_cnt; e0 = err_cnt;
    spi_window({{25{4'h3}}, 28'h0}, 60, cap);
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL short_err_pulses: got %0d expected 1", err_cnt - e0); end
    vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL short_valid_pulses: got %0d expected 0", valid_cnt - v0); end
    vectors++; if (frame_data !== NOM) begin miscompares++; $display("FAIL short_frame_kept: got %h expected %h", frame_data, NOM); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL short_busy: got %b expected 0", busy); end
  endtask

  task automatic test_overrun();
    logic [127:0] cap;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    spi_window({OVF, 4'b1011, 24'h0}, 104, cap);
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL overrun_valid_pulses: got %0d expected 1", valid_cnt - v0); end
    vectors++; if (err_cnt - e0 !== 1) begin miscompares++; $display("FAIL overrun_err_pulses: got %0d expected 1", err_cnt - e0); end
    vectors++; if (frame_data !== OVF) begin miscompares++; $display("FAIL overrun_frame_data: got %h expected %h", frame_data, OVF); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] cap;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    spi_window({PATA, 28'h0}, 100, cap);
    vectors++; if (frame_data !== PATA) begin miscompares++; $display("FAIL b2b_first_data: got %h expected %h", frame_data, PATA); end
    spi_window({PATB, 28'h0}, 100, cap);
    vectors++; if (frame_data !== PATB) begin miscompares++; $display("FAIL b2b_second_data: got %h expected %h", frame_data, PATB); end
    vectors++; if (valid_cnt - v0 !== 2) begin miscompares++; $display("FAIL b2b_valid_pulses: got %0d expected 2", valid_cnt - v0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL b2b_err_pulses: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] cap;
    logic m;
    int v0, e0;
    spi_cs_n = 1'b0;
    #100;
    for (int i = 0; i < 50; i++) spi_bit(RSTF[FB-1-i], m);
    reset_n = 1'b0;
    #15;
    vectors++; if (frame_data !== '0) begin miscompares++; $display("FAIL midrst_frame_data: got %h expected 0", frame_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if (spi_miso !== 1'b0) begin miscompares++; $display("FAIL midrst_miso: got %b expected 0", spi_miso); end
    reset_n = 1'b1;
    #5;
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 60; i++) spi_bit(i[0], m);
    vectors++; if (valid_cnt - v0 !== 0) begin miscompares++; $display("FAIL midrst_no_valid: got %0d expected 0", valid_cnt - v0); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_no_start: got %b expected 0", busy); end
    #50;
    spi_cs_n = 1'b1;
    #200;
    spi_window({RSTF, 28'h0}, 100, cap);
    vectors++; if (frame_data !== RSTF) begin miscompares++; $display("FAIL midrst_next_frame: got %h expected %h", frame_data, RSTF); end
    vectors++; if (valid_cnt - v0 !== 1) begin miscompares++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_cnt - v0); end
    vectors++; if (err_cnt - e0 !== 0) begin miscompares++; $display("FAIL midrst_next_err: got %0d expected 0", err_cnt - e0); end
  endtask

  initial begin
    reset_n   = 1'b0;
    spi_cs_n  = 1'b1;
    spi_sclk  = 1'b0;
    spi_mosi  = 1'b0;
    resp_data = '0;
    #23;
    test_reset();
    reset_n = 1'b1;
    #20;
    test_nominal();
    test_miso();
    test_short();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    vectors++; if (both_cnt !== 0) begin miscompares++; $display("FAIL valid_err_exclusive: got %0d overlaps expected 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- SPI mode-0 slave front end for the Raspberry Pi link. Oversamples SCLK/CS_N/MOSI in the clk domain and assembles one 100-bit command frame per chip-select window.
- Presents each completed frame as a parallel word with a one-cycle valid strobe to the downstream field mapper (hwrite, hreadyin, htrans, hwdata, haddr, prdata).
- Returns a 32-bit response word (APB read data) on MISO during the same window.

Parameters:
- FRAME_BITS, 100, bits per command frame; frame_data width.
- RESP_BITS, 32, response bits shifted out on MISO; resp_data width.
- SYNC_STAGES, 2, synchronizer flops on each SPI input; legal values 2..3.

Ports:
- clk  in  1  system clock; must be at least 4x SCLK frequency.
- reset_n  in  1  asynchronous, active-low reset.
- spi_sclk  in  1  SPI clock from the Pi, asynchronous to clk, idles low.
- spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- spi_mosi  in  1  SPI data from the Pi.
- spi_miso  out  1  SPI data to the Pi.
- resp_data  in  RESP_BITS  response word, sampled on the CS_N falling detect.
- frame_data  out  FRAME_BITS  last good frame; bit 99 = first bit received.
- frame_valid  out  1  one-clk pulse when frame_data updates.
- frame_err  out  1  one-clk pulse on a malformed window.
- busy  out  1  high while state != IDLE.

Behaviour:
- Reset values: frame_data 0, frame_valid 0, frame_err 0, spi_miso 0, busy 0, state IDLE, bit counter 0, sync flops 0 (cs_n sync flops 1).
- Synchronization: SYNC_STAGES flops per input, plus one history flop each for sclk_s and cs_s. Edges are detected as rise = s & ~prev and fall = ~s & prev.
- Protocol: mode 0, MSB first. MOSI is sampled on SCLK rising; MISO changes on SCLK falling.
- States: IDLE, SHIFT, HOLD.
- IDLE, on cs fall: go to SHIFT, clear counter and shift register, load resp shift register from resp_data, set spi_miso = resp_data[RESP_BITS-1] on the same clk.
- SHIFT, sclk rise: shift register <= {sr[FRAME_BITS-2:0], mosi_s}; counter + 1.
- SHIFT, on the rise that brings the counter to FRAME_BITS: frame_data <= the updated shift value, frame_valid = 1 for the next clk, go to HOLD.
- SHIFT, sclk fall: shift the resp register left, zero-fill; spi_miso = new MSB. Once RESP_BITS bits have been sent, spi_miso = 0.
- SHIFT, cs rise before FRAME_BITS bits: frame_err pulse, frame_data unchanged, no frame_valid, go to IDLE.
- HOLD: further sclk rises set an internal overrun flag; data is discarded. On cs rise: go to IDLE; frame_err pulses if overrun is set. Overrun clears on entry to SHIFT.
- Priority: cs rise beats an sclk edge detected in the same clk; that edge is ignored.
- Outputs: spi_miso = 0 whenever state is IDLE. frame_valid and frame_err are never both high.
- Latency: frame_valid rises SYNC_STAGES+2 clk after the 100th SCLK rising edge at the pin (±1 clk for synchronizer phase).
- Counter is 7 bits and saturates at FRAME_BITS; no wrap.
- Reset asserted mid-frame: all state is cleared immediately. The first window after reset deasserts starts only on a fresh cs fall; a cs_n already low at release does not start a frame.

Test Plan:
- Nominal frame, clk 100 MHz, SCLK 10 MHz: send 100 bits = {1,1,2'b10, hwdata 0xDEADBEEF, haddr 0x8000_0004, prdata 0x0000_1234}. Expect frame_data == that pattern, exactly one frame_valid pulse, frame_err 0.
- MISO readback: resp_data = 0xA5A5_0F0F at cs fall. Expect the Pi to capture 0xA5A5_0F0F on its first 32 rising edges, then 0 for bits 33..100.
- Short frame: deassert cs_n after 60 bits. Expect one frame_err pulse, no frame_valid, frame_data still holding the previous frame, busy drops to 0.
- Overrun: send 104 bits. Expect frame_valid after bit 100 with the first 100 bits; frame_err pulses at cs_n rise.
- Back-to-back: two frames with a 2-SCLK cs_n gap, data 0x…AAAA then 0x…5555. Expect two frame_valid pulses with the correct data and no cross-contamination.
- Reset mid-frame: pulse reset_n low after 50 bits with cs_n held low. Expect all outputs 0 and no frame_valid until cs_n toggles high then low. The subsequent full frame is then received correctly.
